req_compactor: RTL and testbench
================================

REQ_COMPACTOR -- requirements
Module: req_compactor

Interface
REQ-001 Parameter WIDTH, default 8: data width per port in bits.
REQ-002 Parameter TAG_W, default 2: request tag width in bits.
REQ-003 Parameter NUM_PORTS, default 4: number of requesting ports, range 2..8.
REQ-004 Parameter NUM_LANES, default 2: number of output lanes, range 1..NUM_PORTS.
REQ-005 Parameter RR_MODE, default 1: 0 = fixed priority (port 0 highest), 1 = round-robin priority.
REQ-006 Derived ID_W = clog2(NUM_PORTS+1): port-id width; id 0 = invalid, id i+1 = port i.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 port_in  in  NUM_PORTS*WIDTH  request data, port i at bits [i*WIDTH +: WIDTH].
REQ-011 port_req_tag_in  in  NUM_PORTS*TAG_W  request tag per port, same packing.
REQ-012 port_in_valid  in  NUM_PORTS  per-port request valid.
REQ-013 port_ready  out  NUM_PORTS  per-port acceptance; a request transfers when valid and ready are both 1.
REQ-014 lane_out  out  NUM_LANES*WIDTH  registered compacted data.
REQ-015 lane_req_tag_out  out  NUM_LANES*TAG_W  registered tag of the request on each lane.
REQ-016 lane_id  out  NUM_LANES*ID_W  source port id on each lane (0 when lane invalid).
REQ-017 lane_out_valid  out  NUM_LANES  per-lane valid.
REQ-018 lane_ready  in  1  downstream accepts the whole output stage this cycle.

Function
REQ-019 Output stage SHALL be one register bank; stage "full" = any lane_out_valid bit set.
REQ-020 accept = !full || lane_ready; the stage SHALL load only when accept = 1.
REQ-021 Priority order SHALL start at port 0 (RR_MODE=0) or at pointer rr_ptr (RR_MODE=1), wrapping NUM_PORTS-1 -> 0.
REQ-022 Grant: the first min(NUM_LANES, #valid) valid ports in priority order SHALL be granted; port_ready[i] = accept && grant[i], combinational from port_in_valid.
REQ-023 Granted requests SHALL be packed into lanes 0,1,... in priority order with data, tag and id; remaining lanes load data 0, tag 0, id 0, valid 0.
REQ-024 Latency SHALL be exactly one cycle from transfer to lane_out_valid.
REQ-025 When full and lane_ready = 0, all lane outputs SHALL hold and port_ready SHALL be all 0.
REQ-026 When full, lane_ready = 1 and no port valid, the stage SHALL load all-invalid (drain).
REQ-027 rr_ptr SHALL update only on a load with at least one grant, to (last granted port + 1) mod NUM_PORTS; otherwise it holds; unused when RR_MODE=0.
REQ-028 Ports not granted SHALL see port_ready = 0 and are expected to hold their request.

Reset
REQ-029 On rst_n = 0 all lane outputs, lane_out_valid and rr_ptr SHALL clear to 0 immediately; port_ready SHALL be 0 while in reset.
REQ-030 Reset mid-operation SHALL discard the stage contents; first load possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package req_pkg SHALL hold PORT_ID_INVALID = 0, the RR_MODE encodings and the port-id width function.
REQ-032 Sub-module rr_grant_select SHALL compute the rotated find-first-NUM_LANES grant vector and lane-to-port index map; the top holds the stage register and rr_ptr.

Verification (NUM_PORTS=4, NUM_LANES=2, WIDTH=8)
REQ-033 Ports 1,3 valid, data 0xA1/0xA3, lane_ready=1 -> port_ready=4'b1010; next cycle lane0 = 0xA1 id 2, lane1 = 0xA3 id 4, valid 2'b11.
REQ-034 RR_MODE=0, all four valid held 3 cycles -> every cycle ready=4'b0011, lanes ids 1,2; ports 2,3 starve.
REQ-035 RR_MODE=1, all four valid held, lane_ready=1 -> grants 4'b0011, 4'b1100, 4'b0011; lane ids (1,2),(3,4),(1,2).
REQ-036 Stage full, lane_ready=0 for 3 cycles, all ports valid -> port_ready=0 and lane outputs unchanged; lane_ready=1 -> new load next cycle.
REQ-037 Only port 2 valid, data 0x5C tag 2'b10 -> lane0 = 0x5C id 3 tag 2'b10, lane1 valid 0 id 0; rr_ptr becomes 3.
REQ-038 rst_n low while stage full -> lane_out_valid=0 and rr_ptr=0 immediately, before next clock edge.

Source files
------------

// File: rtl/req_pkg.sv
// Shared constants and helpers for the request compactor.
// Port ids are 1-based so that id 0 can mark an empty lane.
package req_pkg;

  localparam int unsigned PORT_ID_INVALID = 0;

  localparam int unsigned RR_MODE_FIXED = 0;
  localparam int unsigned RR_MODE_ROUND = 1;

  // Width of a 1-based port id, including the invalid code 0.
  function automatic int unsigned port_id_width(input int unsigned num_ports);
    return $clog2(num_ports + 1);
  endfunction

  // Width of a 0-based port index.
  function automatic int unsigned port_idx_width(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Rotated find-first-N selector: grants up to NUM_LANES valid ports starting at start_i
// and reports, per lane, which port index was packed into it.
module rr_grant_select import req_pkg::*; #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned RR_MODE   = 1,
  parameter int unsigned IDX_W     = port_idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]            valid_i,
  input  logic [IDX_W-1:0]                start_i,
  output logic [NUM_PORTS-1:0]            grant_o,
  output logic [NUM_LANES-1:0]            lane_valid_o,
  output logic [NUM_LANES-1:0][IDX_W-1:0] lane_idx_o,
  output logic                            any_grant_o,
  output logic [IDX_W-1:0]                last_idx_o
);

  logic [IDX_W-1:0] start;

  assign start = (RR_MODE == RR_MODE_ROUND) ? start_i : '0;

  always_comb begin
    int unsigned      cnt;
    int unsigned      pos;
    logic [IDX_W-1:0] pi;
    grant_o      = '0;
    lane_valid_o = '0;
    lane_idx_o   = '0;
    last_idx_o   = '0;
    cnt          = 0;
    pos          = 0;
    pi           = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      pos = 32'(start) + k;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      pi = IDX_W'(pos);
      if (valid_i[pi] && (cnt < NUM_LANES)) begin
        grant_o[pi] = 1'b1;
        last_idx_o  = pi;
        // cnt is the next free lane; scan lanes so the write index stays constant
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
          if (cnt == l) begin
            lane_valid_o[l] = 1'b1;
            lane_idx_o[l]   = pi;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

  assign any_grant_o = |grant_o;

endmodule

// File: rtl/req_compactor.sv
// Compacts up to NUM_LANES of NUM_PORTS valid requests into a single registered output stage,
// with fixed or round-robin priority and whole-stage backpressure.
module req_compactor import req_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned RR_MODE   = 1,
  localparam int unsigned ID_W     = port_id_width(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS*WIDTH-1:0]    port_in,
  input  logic [NUM_PORTS*TAG_W-1:0]    port_req_tag_in,
  input  logic [NUM_PORTS-1:0]          port_in_valid,
  output logic [NUM_PORTS-1:0]          port_ready,
  output logic [NUM_LANES*WIDTH-1:0]    lane_out,
  output logic [NUM_LANES*TAG_W-1:0]    lane_req_tag_out,
  output logic [NUM_LANES*ID_W-1:0]     lane_id,
  output logic [NUM_LANES-1:0]          lane_out_valid,
  input  logic                          lane_ready
);

  localparam int unsigned IDX_W = port_idx_width(NUM_PORTS);

  logic [WIDTH-1:0] port_data [NUM_PORTS];
  logic [TAG_W-1:0] port_tag  [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign port_data[i] = port_in[i*WIDTH +: WIDTH];
    assign port_tag[i]  = port_req_tag_in[i*TAG_W +: TAG_W];
  end

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data_q, lane_data_d;
  logic [NUM_LANES-1:0][TAG_W-1:0] lane_tag_q, lane_tag_d;
  logic [NUM_LANES-1:0][ID_W-1:0]  lane_id_q, lane_id_d;
  logic [NUM_LANES-1:0]            lane_vld_q, lane_vld_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;

  logic                            full;
  logic                            accept;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_LANES-1:0]            sel_valid;
  logic [NUM_LANES-1:0][IDX_W-1:0] sel_idx;
  logic                            any_grant;
  logic [IDX_W-1:0]                last_idx;

  assign full   = |lane_vld_q;
  assign accept = !full || lane_ready;

  rr_grant_select #(
    .NUM_PORTS (NUM_PORTS),
    .NUM_LANES (NUM_LANES),
    .RR_MODE   (RR_MODE),
    .IDX_W     (IDX_W)
  ) u_select (
    .valid_i      (port_in_valid),
    .start_i      (rr_ptr_q),
    .grant_o      (grant),
    .lane_valid_o (sel_valid),
    .lane_idx_o   (sel_idx),
    .any_grant_o  (any_grant),
    .last_idx_o   (last_idx)
  );

  // Gated by rst_n so no transfer is advertised while the stage is held in reset.
  assign port_ready = (rst_n && accept) ? grant : '0;

  always_comb begin
    lane_data_d = lane_data_q;
    lane_tag_d  = lane_tag_q;
    lane_id_d   = lane_id_q;
    lane_vld_d  = lane_vld_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (sel_valid[l]) begin
          lane_data_d[l] = port_data[sel_idx[l]];
          lane_tag_d[l]  = port_tag[sel_idx[l]];
          lane_id_d[l]   = ID_W'(sel_idx[l]) + ID_W'(1);
          lane_vld_d[l]  = 1'b1;
        end else begin
          lane_data_d[l] = '0;
          lane_tag_d[l]  = '0;
          lane_id_d[l]   = ID_W'(PORT_ID_INVALID);
          lane_vld_d[l]  = 1'b0;
        end
      end
      if ((RR_MODE == RR_MODE_ROUND) && any_grant) begin
        rr_ptr_d = (last_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : last_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_data_q <= '0;
      lane_tag_q  <= '0;
      lane_id_q   <= '0;
      lane_vld_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      lane_data_q <= lane_data_d;
      lane_tag_q  <= lane_tag_d;
      lane_id_q   <= lane_id_d;
      lane_vld_q  <= lane_vld_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign lane_out         = lane_data_q;
  assign lane_req_tag_out = lane_tag_q;
  assign lane_id          = lane_id_q;
  assign lane_out_valid   = lane_vld_q;

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (port_ready & ~port_in_valid) == '0);

  a_grant_count: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(grant) <= NUM_LANES);

  a_stall_holds: assert property (@(posedge clk) disable iff (!rst_n)
    (full && !lane_ready) |=> ($stable(lane_out) && $stable(lane_out_valid)
                               && $stable(lane_id)));

endmodule

// File: tb/tb_req_compactor.sv
// Bench for req_compactor: a fixed-priority and a round-robin instance share stimulus and are
// checked against a queue-level model, a vector table and a few hand-written sequences.
module tb_req_compactor;

  localparam int NP = 4;
  localparam int NL = 2;
  localparam int W  = 8;
  localparam int TW = 2;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*W-1:0] port_in;
  logic [NP*TW-1:0] port_tag;
  logic [NP-1:0]   pvalid;
  logic            lane_ready;

  logic [NP-1:0]    pready [2];
  logic [NL*W-1:0]  lout   [2];
  logic [NL*TW-1:0] ltag   [2];
  logic [NL*IW-1:0] lid    [2];
  logic [NL-1:0]    lvld   [2];

  always #5 clk = ~clk;

  req_compactor #(
    .WIDTH(W), .TAG_W(TW), .NUM_PORTS(NP), .NUM_LANES(NL), .RR_MODE(0)
  ) dut_fx (
    .clk(clk), .rst_n(rst_n), .port_in(port_in), .port_req_tag_in(port_tag),
    .port_in_valid(pvalid), .port_ready(pready[0]), .lane_out(lout[0]),
    .lane_req_tag_out(ltag[0]), .lane_id(lid[0]), .lane_out_valid(lvld[0]),
    .lane_ready(lane_ready)
  );

  req_compactor #(
    .WIDTH(W), .TAG_W(TW), .NUM_PORTS(NP), .NUM_LANES(NL), .RR_MODE(1)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n), .port_in(port_in), .port_req_tag_in(port_tag),
    .port_in_valid(pvalid), .port_ready(pready[1]), .lane_out(lout[1]),
    .lane_req_tag_out(ltag[1]), .lane_id(lid[1]), .lane_out_valid(lvld[1]),
    .lane_ready(lane_ready)
  );

  int checks = 0;
  int errors = 0;

  // Model state; index 0 = fixed priority, 1 = round robin.
  int m_ptr  [2];
  bit m_vld  [2][NL];
  int m_data [2][NL];
  int m_tag  [2][NL];
  int m_id   [2][NL];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0;
      for (int l = 0; l < NL; l++) begin
        m_vld[m][l] = 0; m_data[m][l] = 0; m_tag[m][l] = 0; m_id[m][l] = 0;
      end
    end
  endfunction

  function automatic bit m_accept(input int m);
    bit full;
    full = 0;
    for (int l = 0; l < NL; l++) full |= m_vld[m][l];
    return !full || lane_ready;
  endfunction

  // Ports granted this cycle, in priority order.
  function automatic int m_grants(input int m, output int gl [NL]);
    int n;
    int p;
    n = 0;
    for (int i = 0; i < NL; i++) gl[i] = 0;
    for (int k = 0; k < NP; k++) begin
      p = (m_ptr[m] + k) % NP;
      if (pvalid[p] && n < NL) begin
        gl[n] = p;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [NP-1:0] exp_ready(input int m);
    int gl [NL];
    int n;
    logic [NP-1:0] r;
    r = '0;
    if (rst_n && m_accept(m)) begin
      n = m_grants(m, gl);
      for (int i = 0; i < n; i++) r[gl[i]] = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_update();
    int gl [NL];
    int n;
    for (int m = 0; m < 2; m++) begin
      if (m_accept(m)) begin
        n = m_grants(m, gl);
        for (int l = 0; l < NL; l++) begin
          if (l < n) begin
            m_vld[m][l]  = 1;
            m_data[m][l] = int'(port_in[gl[l]*W +: W]);
            m_tag[m][l]  = int'(port_tag[gl[l]*TW +: TW]);
            m_id[m][l]   = gl[l] + 1;
          end else begin
            m_vld[m][l] = 0; m_data[m][l] = 0; m_tag[m][l] = 0; m_id[m][l] = 0;
          end
        end
        if (m == 1 && n > 0) m_ptr[m] = (gl[n-1] + 1) % NP;
      end
    end
  endfunction

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d port_ready", m), 32'(pready[m]), 32'(exp_ready(m)));
      for (int l = 0; l < NL; l++) begin
        chk($sformatf("m%0d lane%0d valid", m, l), 32'(lvld[m][l]), 32'(m_vld[m][l]));
        chk($sformatf("m%0d lane%0d data", m, l), 32'(lout[m][l*W +: W]), m_data[m][l]);
        chk($sformatf("m%0d lane%0d tag", m, l), 32'(ltag[m][l*TW +: TW]), m_tag[m][l]);
        chk($sformatf("m%0d lane%0d id", m, l), 32'(lid[m][l*IW +: IW]), m_id[m][l]);
      end
    end
  endtask

  // Entered and left at posedge+1; checks pre-edge outputs, then advances the model.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_pattern();
    for (int i = 0; i < NP; i++) begin
      port_in[i*W +: W]    = 8'(8'hA0 + i);
      port_tag[i*TW +: TW] = 2'(i);
    end
  endtask

  typedef struct {
    logic [NP-1:0] valid;
    logic          lrdy;
    logic [NP-1:0] rdy_fx;
    logic [NP-1:0] rdy_rr;
    int            id0_fx, id1_fx, id0_rr, id1_rr;
  } vec_t;

  vec_t tbl [$];

  initial begin
    rst_n      = 1'b1;
    pvalid     = '0;
    lane_ready = 1'b1;
    port_in    = '0;
    port_tag   = '0;
    model_clear();
    #1;
    do_reset();

    tbl.push_back('{4'b1111, 1'b1, 4'b0011, 4'b0011, 1, 2, 1, 2});
    tbl.push_back('{4'b1111, 1'b1, 4'b0011, 4'b1100, 1, 2, 3, 4});
    tbl.push_back('{4'b1111, 1'b1, 4'b0011, 4'b0011, 1, 2, 1, 2});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 4'b0000, 1, 2, 1, 2});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 4'b0000, 1, 2, 1, 2});
    tbl.push_back('{4'b1111, 1'b0, 4'b0000, 4'b0000, 1, 2, 1, 2});
    tbl.push_back('{4'b1111, 1'b1, 4'b0011, 4'b1100, 1, 2, 3, 4});
    tbl.push_back('{4'b1010, 1'b1, 4'b1010, 4'b1010, 2, 4, 2, 4});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0});
    tbl.push_back('{4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0});

    set_pattern();
    for (int i = 0; i < tbl.size(); i++) begin
      pvalid     = tbl[i].valid;
      lane_ready = tbl[i].lrdy;
      #1;
      chk($sformatf("vec%0d fx ready", i), 32'(pready[0]), 32'(tbl[i].rdy_fx));
      chk($sformatf("vec%0d rr ready", i), 32'(pready[1]), 32'(tbl[i].rdy_rr));
      cycle();
      chk($sformatf("vec%0d fx id0", i), 32'(lid[0][0 +: IW]), tbl[i].id0_fx);
      chk($sformatf("vec%0d fx id1", i), 32'(lid[0][IW +: IW]), tbl[i].id1_fx);
      chk($sformatf("vec%0d rr id0", i), 32'(lid[1][0 +: IW]), tbl[i].id0_rr);
      chk($sformatf("vec%0d rr id1", i), 32'(lid[1][IW +: IW]), tbl[i].id1_rr);
    end

    // Single request on port 2: packs into lane 0 and moves the pointer to 3.
    port_in[2*W +: W]    = 8'h5C;
    port_tag[2*TW +: TW] = 2'b10;
    pvalid     = 4'b0100;
    lane_ready = 1'b1;
    #1;
    chk("single rr ready", 32'(pready[1]), 32'h4);
    cycle();
    chk("single lane0 data", 32'(lout[1][0 +: W]), 32'h5C);
    chk("single lane0 id", 32'(lid[1][0 +: IW]), 32'd3);
    chk("single lane0 tag", 32'(ltag[1][0 +: TW]), 32'h2);
    chk("single valid", 32'(lvld[1]), 32'b01);
    chk("single lane1 id", 32'(lid[1][IW +: IW]), 32'd0);
    set_pattern();
    pvalid = 4'b1111;
    #1;
    chk("wrap rr ready", 32'(pready[1]), 32'b1001);
    cycle();
    chk("wrap lane0 id", 32'(lid[1][0 +: IW]), 32'd4);
    chk("wrap lane1 id", 32'(lid[1][IW +: IW]), 32'd1);

    // Asynchronous reset while the stage is full and stalled.
    lane_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async rst fx valid", 32'(lvld[0]), 32'd0);
    chk("async rst rr valid", 32'(lvld[1]), 32'd0);
    chk("async rst rr ids", 32'(lid[1]), 32'd0);
    chk("async rst ready", 32'(pready[1]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post rst rr ready", 32'(pready[1]), 32'b0011);
    cycle();
    chk("post rst rr id0", 32'(lid[1][0 +: IW]), 32'd1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      pvalid     = 4'($urandom_range(0, 15));
      lane_ready = ($urandom_range(0, 3) != 0);
      port_in    = 32'($urandom());
      port_tag   = 8'($urandom());
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
